// File: rtl/id_operand_stage.sv
// id_operand_stage
//   Decode-side operand stage between the register file and EX.
//   Selects operands (register 0 forced to zero, same-cycle WB bypass),
//   detects load-use hazards, and holds the ID/EX pipeline register under
//   EX backpressure. Flush kills both the decode slot and the output register.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid               decoded instruction present
//   i_rs, i_rt            source indices (also drive the register file reads)
//   i_uses_rs, i_uses_rt  instruction actually reads rs / rt
//   i_dst, i_reg_wr       destination index and write enable
//   i_is_load             instruction is a load
//   i_rd_data_1/2         register file read data for rs / rt
//   i_wb_reg_wr, i_wb_reg, i_wb_data   writeback port (bypass source)
//   i_ex_ready            EX accepts the current output
//   i_flush               kill decode and output register
//   o_stall               hold IF/ID (combinational)
//   o_valid, o_op_a, o_op_b, o_dst, o_reg_wr, o_is_load   ID/EX register
//   o_bubble_cnt          saturating count of load-use bubbles
module id_operand_stage #(
    parameter int WORD_SIZE     = 32,
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [REG_ADDR_SIZE-1:0] i_rs,
    input  logic [REG_ADDR_SIZE-1:0] i_rt,
    input  logic                     i_uses_rs,
    input  logic                     i_uses_rt,
    input  logic [REG_ADDR_SIZE-1:0] i_dst,
    input  logic                     i_reg_wr,
    input  logic                     i_is_load,
    input  logic [WORD_SIZE-1:0]     i_rd_data_1,
    input  logic [WORD_SIZE-1:0]     i_rd_data_2,
    input  logic                     i_wb_reg_wr,
    input  logic [REG_ADDR_SIZE-1:0] i_wb_reg,
    input  logic [WORD_SIZE-1:0]     i_wb_data,
    input  logic                     i_ex_ready,
    input  logic                     i_flush,
    output logic                     o_stall,
    output logic                     o_valid,
    output logic [WORD_SIZE-1:0]     o_op_a,
    output logic [WORD_SIZE-1:0]     o_op_b,
    output logic [REG_ADDR_SIZE-1:0] o_dst,
    output logic                     o_reg_wr,
    output logic                     o_is_load,
    output logic [15:0]              o_bubble_cnt
);

    localparam logic [REG_ADDR_SIZE-1:0] REG_ZERO = '0;
    localparam logic [15:0]              CNT_MAX  = 16'hFFFF;

    logic [WORD_SIZE-1:0] op_a_sel;
    logic [WORD_SIZE-1:0] op_b_sel;
    logic                 rs_match;
    logic                 rt_match;
    logic                 hz;
    logic                 bp;

    // Register 0 wins over the bypass so a WB to r0 can never leak through.
    always_comb begin
        if (i_rs == REG_ZERO)
            op_a_sel = '0;
        else if (i_wb_reg_wr && (i_wb_reg == i_rs))
            op_a_sel = i_wb_data;
        else
            op_a_sel = i_rd_data_1;

        if (i_rt == REG_ZERO)
            op_b_sel = '0;
        else if (i_wb_reg_wr && (i_wb_reg == i_rt))
            op_b_sel = i_wb_data;
        else
            op_b_sel = i_rd_data_2;
    end

    assign rs_match = i_uses_rs && (i_rs == o_dst);
    assign rt_match = i_uses_rt && (i_rt == o_dst);

    // A load sitting in the output register whose result the decoding
    // instruction needs; a load to r0 produces nothing to wait for.
    assign hz = o_valid && o_is_load && o_reg_wr && (o_dst != REG_ZERO)
                && i_valid && (rs_match || rt_match);
    assign bp = o_valid && !i_ex_ready;

    assign o_stall = !i_flush && (hz || bp);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_op_a       <= '0;
            o_op_b       <= '0;
            o_dst        <= '0;
            o_reg_wr     <= 1'b0;
            o_is_load    <= 1'b0;
            o_bubble_cnt <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (bp) begin
            // hold everything until EX takes the current output
        end else if (hz) begin
            o_valid <= 1'b0;
            if (o_bubble_cnt != CNT_MAX)
                o_bubble_cnt <= o_bubble_cnt + 16'd1;
        end else begin
            o_valid   <= i_valid;
            o_op_a    <= op_a_sel;
            o_op_b    <= op_b_sel;
            o_dst     <= i_dst;
            o_reg_wr  <= i_reg_wr;
            o_is_load <= i_is_load;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dst;
        logic        wr;
        logic        ld;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses_rs;
    logic        uses_rt;
    logic [4:0]  dst;
    logic        reg_wr;
    logic        is_load;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_wr;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        flush;
    logic        stall;
    logic        o_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  o_dst;
    logic        o_reg_wr;
    logic        o_is_load;
    logic [15:0] bubble_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    id_operand_stage #(.WORD_SIZE(32), .REG_ADDR_SIZE(5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_rs         (rs),
        .i_rt         (rt),
        .i_uses_rs    (uses_rs),
        .i_uses_rt    (uses_rt),
        .i_dst        (dst),
        .i_reg_wr     (reg_wr),
        .i_is_load    (is_load),
        .i_rd_data_1  (rd1),
        .i_rd_data_2  (rd2),
        .i_wb_reg_wr  (wb_wr),
        .i_wb_reg     (wb_reg),
        .i_wb_data    (wb_data),
        .i_ex_ready   (ex_ready),
        .i_flush      (flush),
        .o_stall      (stall),
        .o_valid      (o_valid),
        .o_op_a       (op_a),
        .o_op_b       (op_b),
        .o_dst        (o_dst),
        .o_reg_wr     (o_reg_wr),
        .o_is_load    (o_is_load),
        .o_bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: an output accepted by EX is compared against the head of the
    // scoreboard; an output killed by flush or reset is dropped.
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (o_valid === 1'b1) begin
            if (rst || flush) begin
                if (sb.size() > 0) e = sb.pop_front();
            end else if (ex_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty actual=output_present required=none");
                end else begin
                    e = sb.pop_front();
                    g = '{a: op_a, b: op_b, dst: o_dst, wr: o_reg_wr, ld: o_is_load};
                    if (g !== e) begin
                        errors++;
                        $display("FAIL packet actual=%h required=%h", g, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 0; rs = 0; rt = 0; uses_rs = 0; uses_rt = 0;
        dst = 0; reg_wr = 0; is_load = 0; rd1 = 0; rd2 = 0;
        wb_wr = 0; wb_reg = 0; wb_data = 0; ex_ready = 1; flush = 0;
    endtask

    task automatic set_instr(input logic [4:0] a_rs, input logic [31:0] a_rd1, input logic a_urs,
                             input logic [4:0] a_rt, input logic [31:0] a_rd2, input logic a_urt,
                             input logic [4:0] a_dst, input logic a_wr, input logic a_ld);
        valid = 1; rs = a_rs; rd1 = a_rd1; uses_rs = a_urs;
        rt = a_rt; rd2 = a_rd2; uses_rt = a_urt;
        dst = a_dst; reg_wr = a_wr; is_load = a_ld;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                        input logic w, input logic l);
        exp_t e;
        e = '{a: a, b: b, dst: d, wr: w, ld: l};
        sb.push_back(e);
    endtask

    initial begin
        idle();
        // reset with random inputs
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            valid = 1'($urandom); rs = 5'($urandom); rt = 5'($urandom);
            uses_rs = 1'($urandom); uses_rt = 1'($urandom); dst = 5'($urandom);
            reg_wr = 1'($urandom); is_load = 1'($urandom); rd1 = $urandom; rd2 = $urandom;
            wb_wr = 1'($urandom); wb_reg = 5'($urandom); wb_data = $urandom;
            ex_ready = 1'($urandom); flush = 1'($urandom);
            step();
        end
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_dst", 32'(o_dst), 0);
        chk("rst_reg_wr", 32'(o_reg_wr), 0);
        chk("rst_is_load", 32'(o_is_load), 0);
        chk("rst_bubble", 32'(bubble_cnt), 0);
        rst = 0;
        idle();
        step();

        // register 0 ignores rf data and WB bypass
        set_instr(0, 32'hDEADBEEF, 1, 0, 32'hCAFE, 1, 1, 1, 0);
        wb_wr = 1; wb_reg = 0; wb_data = 5;
        push(0, 0, 1, 1, 0);
        step();
        chk("reg0_op_a", op_a, 0);

        // WB bypass on rt
        set_instr(2, 32'h100, 1, 7, 32'h11, 1, 4, 1, 0);
        wb_wr = 1; wb_reg = 7; wb_data = 32'h22;
        push(32'h100, 32'h22, 4, 1, 0);
        step();
        chk("byp_op_b", op_b, 32'h22);

        // WB to another register: rt from rf, rs bypassed
        set_instr(8, 32'h200, 1, 7, 32'h11, 1, 4, 1, 0);
        wb_reg = 8;
        push(32'h22, 32'h11, 4, 1, 0);
        step();
        chk("nobyp_op_b", op_b, 32'h11);
        wb_wr = 0; wb_reg = 0; wb_data = 0;

        // load-use on rs: exactly one bubble
        set_instr(1, 32'h40, 1, 0, 0, 0, 3, 1, 1);
        #1 chk("lu_stall_c0", 32'(stall), 0);
        push(32'h40, 0, 3, 1, 1);
        step();
        set_instr(3, 32'hAAAA, 1, 5, 32'h55, 1, 6, 1, 0);
        #1 chk("lu_stall_c1", 32'(stall), 1);
        step();
        chk("lu_bubble_valid", 32'(o_valid), 0);
        chk("lu_bubble_cnt", 32'(bubble_cnt), 1);
        chk("lu_stall_c2", 32'(stall), 0);
        wb_wr = 1; wb_reg = 3; wb_data = 32'h77;
        push(32'h77, 32'h55, 6, 1, 0);
        step();
        chk("lu_capture_valid", 32'(o_valid), 1);
        wb_wr = 0; wb_reg = 0; wb_data = 0;

        // backpressure: hold for 3 cycles
        set_instr(9, 32'h9, 1, 0, 0, 0, 10, 1, 0);
        push(32'h9, 0, 10, 1, 0);
        step();
        ex_ready = 0;
        set_instr(2, 32'h1234, 1, 3, 32'h5678, 1, 11, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_stall", 32'(stall), 1);
            chk("bp_op_a", op_a, 32'h9);
            chk("bp_dst", 32'(o_dst), 10);
            chk("bp_valid", 32'(o_valid), 1);
            step();
        end
        ex_ready = 1;
        #1 chk("bp_release_stall", 32'(stall), 0);
        push(32'h1234, 32'h5678, 11, 1, 0);
        step();
        chk("bp_capture_op_a", op_a, 32'h1234);

        // flush beats hazard and backpressure
        set_instr(0, 0, 0, 0, 0, 0, 4, 1, 1);
        push(0, 0, 4, 1, 1);
        step();
        set_instr(4, 32'h1, 1, 0, 0, 0, 0, 0, 0);
        ex_ready = 0; flush = 1;
        #1 chk("fl_stall", 32'(stall), 0);
        step();
        chk("fl_valid", 32'(o_valid), 0);
        chk("fl_bubble_cnt", 32'(bubble_cnt), 1);
        idle();
        step();

        // load to r0 never creates a hazard
        set_instr(0, 0, 0, 0, 0, 0, 0, 1, 1);
        push(0, 0, 0, 1, 1);
        step();
        set_instr(0, 32'hBAD, 1, 0, 0, 0, 2, 1, 0);
        #1 chk("r0load_stall", 32'(stall), 0);
        push(0, 0, 2, 1, 0);
        step();
        chk("r0load_valid", 32'(o_valid), 1);
        chk("r0load_cnt", 32'(bubble_cnt), 1);

        // load-use via rt
        set_instr(0, 0, 0, 0, 0, 0, 5, 1, 1);
        push(0, 0, 5, 1, 1);
        step();
        set_instr(1, 32'h10, 1, 5, 32'h99, 1, 7, 1, 0);
        #1 chk("rt_lu_stall", 32'(stall), 1);
        step();
        chk("rt_lu_valid", 32'(o_valid), 0);
        chk("rt_lu_cnt", 32'(bubble_cnt), 2);
        push(32'h10, 32'h99, 7, 1, 0);
        step();
        chk("rt_lu_capture", 32'(o_valid), 1);

        // reset in the middle of a stall
        set_instr(0, 0, 0, 0, 0, 0, 6, 1, 1);
        push(0, 0, 6, 1, 1);
        step();
        set_instr(6, 32'h3, 1, 0, 0, 0, 1, 1, 0);
        rst = 1;
        #1 chk("rst_stall_stall", 32'(stall), 1);
        step();
        chk("rst_stall_valid", 32'(o_valid), 0);
        chk("rst_stall_cnt", 32'(bubble_cnt), 0);
        rst = 0;
        idle();
        step();
        step();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-side operand stage that sits directly downstream of the register file and feeds the EX stage.
- Takes the two read ports of the register file and applies a same-cycle writeback bypass. It also forces register 0 to read as zero.
- Detects load-use hazards, registers the operands and control into the ID/EX pipeline register, and handles EX backpressure and flushes.

Parameters:
- WORD_SIZE, 32, data word width.
- REG_ADDR_SIZE, 5, register index width; matches the register file read/write index width.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  decoded instruction present this cycle.
- i_rs  input  REG_ADDR_SIZE  source register A index (also drives register file read port 1).
- i_rt  input  REG_ADDR_SIZE  source register B index (also drives register file read port 2).
- i_uses_rs  input  1  instruction reads rs.
- i_uses_rt  input  1  instruction reads rt.
- i_dst  input  REG_ADDR_SIZE  destination register index.
- i_reg_wr  input  1  instruction writes i_dst.
- i_is_load  input  1  instruction is a load.
- i_rd_data_1  input  WORD_SIZE  register file read data for rs.
- i_rd_data_2  input  WORD_SIZE  register file read data for rt.
- i_wb_reg_wr  input  1  WB stage writes the register file this cycle.
- i_wb_reg  input  REG_ADDR_SIZE  WB destination index.
- i_wb_data  input  WORD_SIZE  WB write data.
- i_ex_ready  input  1  EX accepts the current output this cycle.
- i_flush  input  1  kill the instruction in decode and in the output register.
- o_stall  output  1  hold IF/ID (combinational).
- o_valid  output  1  output register holds a live instruction.
- o_op_a  output  WORD_SIZE  registered operand A.
- o_op_b  output  WORD_SIZE  registered operand B.
- o_dst  output  REG_ADDR_SIZE  registered destination.
- o_reg_wr  output  1  registered write enable.
- o_is_load  output  1  registered load flag.
- o_bubble_cnt  output  16  count of load-use bubbles inserted, saturating.

Behaviour:
- Reset: while i_rst is high at a rising edge, all registered outputs go to 0 next cycle (o_valid, o_op_a, o_op_b, o_dst, o_reg_wr, o_is_load, o_bubble_cnt). Reset overrides every other input.
- Operand select for A (B is the same using i_rt and i_rd_data_2):
  - if i_rs == 0: value is 0; never bypassed; register file data ignored.
  - else if i_wb_reg_wr and i_wb_reg == i_rs: value is i_wb_data.
  - otherwise: value is i_rd_data_1.
- Hazard term: hz = o_valid & o_is_load & o_reg_wr & (o_dst != 0) & i_valid & ((i_uses_rs & i_rs == o_dst) | (i_uses_rt & i_rt == o_dst)).
- Backpressure term: bp = o_valid & !i_ex_ready.
- o_stall = !i_flush & (hz | bp). It is combinational; upstream holds its instruction while o_stall is high.
- Next-state priority, evaluated at each rising edge:
  1. Reset.
  2. i_flush: o_valid <= 0; other outputs don't-care; o_bubble_cnt unchanged.
  3. bp: all outputs hold their values.
  4. hz (with i_ex_ready high): insert a bubble. o_valid <= 0, o_bubble_cnt increments, saturating at 16'hFFFF.
  5. Otherwise: capture. o_valid <= i_valid; operands per the select rule; o_dst, o_reg_wr and o_is_load from the inputs.
- Latency: one cycle from decode to o_*. A load-use pair costs exactly one bubble.
- After a bubble, hz is false on the next cycle (o_valid is 0), so the held instruction is captured. Its operand comes via WB bypass or a forwarding path downstream, never stale register file data for reg 0.
- When i_valid is low, capture still writes o_valid <= 0; operand values are don't-care.
- Reset asserted mid-stall: the stall is abandoned and the next cycle is the reset state. o_stall is still computed from the current registers during the reset cycle.

Test Plan:
- Reset: hold i_rst high 2 cycles with random inputs -> all registered outputs are 0, including o_bubble_cnt = 0.
- Reg-0 read: i_rs = 0, i_rd_data_1 = 32'hDEADBEEF, i_wb_reg_wr = 1, i_wb_reg = 0, i_wb_data = 5 -> o_op_a = 0 next cycle.
- WB bypass: i_rt = 7, i_rd_data_2 = 32'h11, i_wb_reg_wr = 1, i_wb_reg = 7, i_wb_data = 32'h22 -> o_op_b = 32'h22. With i_wb_reg = 8 instead -> o_op_b = 32'h11.
- Load-use stall:
  - cycle 0: load with i_dst = 3, i_is_load = 1, i_reg_wr = 1.
  - cycle 1: add with i_rs = 3, i_uses_rs = 1.
  - Required: o_stall = 1 in cycle 1; o_valid = 0 in cycle 2; o_bubble_cnt = 1; add captured with o_valid = 1 in cycle 3.
- Backpressure: o_valid = 1 with o_op_a = 9, i_ex_ready low 3 cycles, new inputs applied -> o_stall = 1 and outputs unchanged all 3 cycles; capture occurs on the cycle i_ex_ready returns high.
- Flush priority: flush during a hazard with i_ex_ready = 0 -> o_stall = 0, o_valid = 0 next cycle, o_bubble_cnt unchanged.
